// File: rtl/locked_check_pkg.sv
`default_nettype none
// ============================================================================
// Package   : locked_check_pkg
// Brief     : Shared FSM states and Hamming-distance helpers for the checker.
// Revision  : 1.0
// ============================================================================
package locked_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_MUL  = 3'd2,
    ST_CMP  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Widest vector popcount() can take; callers zero-extend to this width.
  localparam int POP_MAX_W = 128;

  // Bits needed to hold a Hamming distance of 0..2*width.
  function automatic int hd_width(input int width);
    return $clog2(2 * width + 1);
  endfunction

  // Counts set bits among the low 'width' bits of vec.
  function automatic int popcount(input logic [POP_MAX_W-1:0] vec, input int width);
    int n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      if ((i < width) && vec[i]) begin
        n++;
      end
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_shift_add_mul.sv
`default_nettype none
// ============================================================================
// Module    : seq_shift_add_mul
// Brief     : Unsigned LSB-first shift-add multiplier, one partial product per
//             cycle, WIDTH cycles per operation after the start cycle.
// Revision  : 1.0
// ============================================================================
module seq_shift_add_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      cnt_d    = CW'(WIDTH);
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // done flags the final accumulate cycle; product is complete from the next cycle.
  assign busy    = (cnt_q != '0);
  assign done    = (cnt_q == CW'(1));
  assign product = acc_q;

endmodule
`default_nettype wire

// File: rtl/locked_output_checker.sv
`default_nettype none
// ============================================================================
// Module    : locked_output_checker
// Brief     : Golden-model checker for a locked multiplier's result stream;
//             accumulates per-run Hamming-distance error statistics.
// Revision  : 1.0
// ============================================================================
module locked_output_checker
  import locked_check_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int VEC_COUNT = 10000,
  parameter int CNT_W     = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           operand1_i,
  input  logic [WIDTH-1:0]           operand2_i,
  input  logic [2*WIDTH-1:0]         result_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [CNT_W-1:0]           vec_cnt_o,
  output logic [CNT_W-1:0]           err_vec_cnt_o,
  output logic [CNT_W-1:0]           hd_sum_o,
  output logic [hd_width(WIDTH)-1:0] max_hd_o
);

  localparam int PW    = 2 * WIDTH;
  localparam int HD_W  = hd_width(WIDTH);
  localparam int SUM_W = CNT_W + 1;

  if ((VEC_COUNT < 1) || (longint'(VEC_COUNT) >= (longint'(1) << CNT_W)) ||
      (PW > POP_MAX_W)) begin : g_cfg_check
    $error("locked_output_checker: VEC_COUNT must be in 1..2^CNT_W-1 and 2*WIDTH <= POP_MAX_W");
  end

  state_e           state_q, state_d;
  logic [PW-1:0]    result_q, result_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] hd_sum_q, hd_sum_d;
  logic [HD_W-1:0]  max_hd_q, max_hd_d;
  logic [HD_W-1:0]  hd;
  logic [SUM_W-1:0] hd_sum_ext;

  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [PW-1:0]    mul_product;

  // The multiplier latches the operands itself on mul_start, so only the
  // observed result needs a local capture register.
  seq_shift_add_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start   (mul_start),
    .a       (operand1_i),
    .b       (operand2_i),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    vec_cnt_d  = vec_cnt_q;
    err_cnt_d  = err_cnt_q;
    hd_sum_d   = hd_sum_q;
    max_hd_d   = max_hd_q;
    mul_start  = 1'b0;
    hd         = HD_W'(popcount(POP_MAX_W'(mul_product ^ result_q), PW));
    hd_sum_ext = {1'b0, hd_sum_q} + SUM_W'(hd);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          vec_cnt_d = '0;
          err_cnt_d = '0;
          hd_sum_d  = '0;
          max_hd_d  = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (in_valid_i) begin
          result_d  = result_i;
          mul_start = 1'b1;
          state_d   = ST_MUL;
        end
      end
      ST_MUL: begin
        if (mul_done || !mul_busy) begin
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        vec_cnt_d = vec_cnt_q + CNT_W'(1);
        if (hd != '0) begin
          err_cnt_d = err_cnt_q + CNT_W'(1);
        end
        hd_sum_d = hd_sum_ext[CNT_W] ? '1 : hd_sum_ext[CNT_W-1:0];
        if (hd > max_hd_q) begin
          max_hd_d = hd;
        end
        state_d = (vec_cnt_d == CNT_W'(VEC_COUNT)) ? ST_DONE : ST_WAIT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      vec_cnt_q <= '0;
      err_cnt_q <= '0;
      hd_sum_q  <= '0;
      max_hd_q  <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      vec_cnt_q <= vec_cnt_d;
      err_cnt_q <= err_cnt_d;
      hd_sum_q  <= hd_sum_d;
      max_hd_q  <= max_hd_d;
    end
  end

  assign in_ready_o    = (state_q == ST_WAIT);
  assign busy_o        = (state_q == ST_WAIT) || (state_q == ST_MUL) || (state_q == ST_CMP);
  assign done_o        = (state_q == ST_DONE);
  assign vec_cnt_o     = vec_cnt_q;
  assign err_vec_cnt_o = err_cnt_q;
  assign hd_sum_o      = hd_sum_q;
  assign max_hd_o      = max_hd_q;

endmodule
`default_nettype wire

// File: tb/tb_locked_output_checker.sv
`default_nettype none
// ============================================================================
// Module    : tb_locked_output_checker
// Brief     : Self-checking bench: cycle-level reference model plus literals.
// Revision  : 1.0
// ============================================================================
module tb_locked_output_checker;

  localparam int WIDTH     = 8;
  localparam int VEC_COUNT = 4;
  localparam int CNT_W     = 32;
  localparam int HD_W      = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             in_valid;
  logic [7:0]       op1, op2;
  logic [15:0]      res;
  logic             in_ready_o, busy_o, done_o;
  logic [CNT_W-1:0] vec_cnt_o, err_vec_cnt_o, hd_sum_o;
  logic [HD_W-1:0]  max_hd_o;

  always #5 clk = ~clk;

  locked_output_checker #(
    .WIDTH     (WIDTH),
    .VEC_COUNT (VEC_COUNT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready_o),
    .operand1_i    (op1),
    .operand2_i    (op2),
    .result_i      (res),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .vec_cnt_o     (vec_cnt_o),
    .err_vec_cnt_o (err_vec_cnt_o),
    .hd_sum_o      (hd_sum_o),
    .max_hd_o      (max_hd_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit spacing_en = 1'b0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: run phase 0=idle 1=ready 2=vector in flight 3=done.
  int          m_phase = 0;
  int          m_left  = 0;
  logic [15:0] m_prod  = '0;
  logic [15:0] m_res   = '0;
  longint      m_vec = 0, m_err = 0, m_sum = 0;
  int          m_max = 0;
  int          cyc   = 0;

  initial begin
    int hd;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_phase = 0; m_left = 0; m_vec = 0; m_err = 0; m_sum = 0; m_max = 0;
      end else begin
        cyc++;
        case (m_phase)
          0, 3: if (start) begin
            m_vec = 0; m_err = 0; m_sum = 0; m_max = 0; m_phase = 1;
          end
          1: if (in_valid) begin
            m_prod  = 16'(int'(op1) * int'(op2));
            m_res   = res;
            m_left  = WIDTH + 1;
            m_phase = 2;
          end
          2: begin
            m_left--;
            if (m_left == 0) begin
              hd = $countones(m_prod ^ m_res);
              m_vec++;
              if (hd != 0) m_err++;
              m_sum = m_sum + hd;
              if (m_sum > 64'hFFFF_FFFF) m_sum = 64'hFFFF_FFFF;
              if (hd > m_max) m_max = hd;
              m_phase = (m_vec == VEC_COUNT) ? 3 : 1;
            end
          end
          default: m_phase = 0;
        endcase
      end
    end
  end

  // Compare DUT against the model mid-cycle, every cycle.
  initial begin
    int prev_acc;
    prev_acc = -1;
    forever begin
      @(negedge clk);
      check("in_ready", in_ready_o, m_phase == 1);
      check("busy", busy_o, (m_phase == 1) || (m_phase == 2));
      check("done", done_o, m_phase == 3);
      check("vec_cnt", vec_cnt_o, m_vec);
      check("err_vec_cnt", err_vec_cnt_o, m_err);
      check("hd_sum", hd_sum_o, m_sum);
      check("max_hd", max_hd_o, m_max);
      if (!spacing_en) prev_acc = -1;
      else if (in_ready_o && in_valid) begin
        if (prev_acc >= 0) check("accept_spacing", cyc + 1 - prev_acc, WIDTH + 2);
        prev_acc = cyc + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] r);
    bit ok, rdy;
    ok = 1'b0;
    op1 = a; op2 = b; res = r; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rdy = in_ready_o;
      tick();
      if (rdy) begin ok = 1'b1; break; end
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready_o) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_o) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  function automatic logic [15:0] rand_res(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p, mask;
    p = 16'(int'(a) * int'(b));
    case ($urandom_range(0, 3))
      0:       mask = 16'h0000;
      1:       mask = 16'h0001 << $urandom_range(0, 15);
      2:       mask = 16'($urandom);
      default: mask = 16'hFFFF;
    endcase
    return p ^ mask;
  endfunction

  task automatic random_vec();
    logic [7:0] a, b;
    a = 8'($urandom);
    b = 8'($urandom);
    repeat ($urandom_range(0, 3)) tick();
    send(a, b, rand_res(a, b));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; op1 = '0; op2 = '0; res = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_vec_cnt", vec_cnt_o, 0);

    // Clean products: no errors expected.
    pulse_start();
    send(8'h03, 8'h05, 16'h000F);
    send(8'hFF, 8'hFF, 16'hFE01);
    send(8'h00, 8'hA5, 16'h0000);
    send(8'h80, 8'h02, 16'h0100);
    wait_done();
    check("clean_done", done_o, 1);
    check("clean_vec_cnt", vec_cnt_o, 4);
    check("clean_err", err_vec_cnt_o, 0);
    check("clean_hd_sum", hd_sum_o, 0);
    check("clean_max_hd", max_hd_o, 0);

    // Restart from DONE clears stats and done.
    pulse_start();
    check("restart_done_low", done_o, 0);
    check("restart_vec_cleared", vec_cnt_o, 0);
    check("restart_ready", in_ready_o, 1);

    send(8'h0C, 8'h0A, 16'h0079);
    wait_ready();
    check("onebit_err", err_vec_cnt_o, 1);
    check("onebit_hd_sum", hd_sum_o, 1);
    check("onebit_max_hd", max_hd_o, 1);
    send(8'hFF, 8'hFF, 16'h01FE);
    wait_ready();
    check("invert_max_hd", max_hd_o, 16);
    check("invert_hd_sum", hd_sum_o, 17);
    // start during WAIT is ignored.
    pulse_start();
    check("wait_start_vec_cnt", vec_cnt_o, 2);
    check("wait_start_ready", in_ready_o, 1);
    send(8'h03, 8'h05, 16'h000F);
    wait_ready();
    check("clean_after_invert_max", max_hd_o, 16);
    send(8'h0C, 8'h0A, 16'h0078);
    wait_done();
    check("mixed_err", err_vec_cnt_o, 2);
    check("mixed_hd_sum", hd_sum_o, 17);

    // Reset during MUL of the third vector.
    pulse_start();
    send(8'h11, 8'h22, 16'h0242);
    send(8'h33, 8'h44, 16'h0000);
    send(8'h55, 8'h66, 16'h21DE);
    tick(); tick();
    rst = 1'b1;
    #1;
    check("abort_busy", busy_o, 0);
    check("abort_ready", in_ready_o, 0);
    check("abort_vec_cnt", vec_cnt_o, 0);
    check("abort_err", err_vec_cnt_o, 0);
    check("abort_hd_sum", hd_sum_o, 0);
    tick();
    rst = 1'b0;
    tick();
    pulse_start();
    check("fresh_vec_cnt", vec_cnt_o, 0);
    send(8'h0C, 8'h0A, 16'h0079);
    send(8'h03, 8'h05, 16'h000F);
    send(8'hFF, 8'hFF, 16'h01FE);
    send(8'h00, 8'hA5, 16'h0000);
    wait_done();
    check("fresh_vec_cnt_done", vec_cnt_o, 4);
    check("fresh_err", err_vec_cnt_o, 2);
    check("fresh_hd_sum", hd_sum_o, 17);
    check("fresh_max_hd", max_hd_o, 16);

    // Streaming: valid held high, data changing every cycle.
    for (int r = 0; r < 4; r++) begin
      pulse_start();
      spacing_en = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
        op1 = 8'($urandom);
        op2 = 8'($urandom);
        res = rand_res(op1, op2);
        tick();
        if (done_o) break;
      end
      in_valid = 1'b0;
      spacing_en = 1'b0;
      check("stream_done", done_o, 1);
    end

    // Randomized runs with idle gaps.
    for (int r = 0; r < 6; r++) begin
      pulse_start();
      for (int v = 0; v < VEC_COUNT; v++) random_vec();
      wait_done();
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
